// File: rtl/spi_pkg.sv
// Shared definitions for the clk-domain SPI slave: FSM encoding, default frame width
// and the CPOL/CPHA sample-edge select.
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    typedef enum logic {
        SPI_IDLE   = 1'b0,
        SPI_ACTIVE = 1'b1
    } spi_state_t;

    // 1 when the sample edge is a rising sclk edge (modes 0 and 3)
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return ~(cpol ^ cpha);
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for one asynchronous pin, plus rise/fall detection of the
// synchronized level against its previous value.
module spi_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_sync.sv
// Oversampling SPI slave (LSB first, all CPOL/CPHA modes) with valid/ready byte ports.
// Optional SPI_SLV_ERR_FLAGS_EN adds rx_overrun/tx_underrun pulses and drop-on-overrun.
//   state      | meaning
//   SPI_IDLE   | ss deasserted, sclk edges ignored
//   SPI_ACTIVE | frame in progress, sampling/shifting on sclk edges
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int                DATA_W      = SPI_DATA_W,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] DEFAULT_TX  = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              CPOL,
    input  logic              CPHA,
    input  logic              sclk,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
`ifdef SPI_SLV_ERR_FLAGS_EN
    output logic              rx_overrun,
    output logic              tx_underrun,
`endif
    input  logic              rx_ready
);

    localparam int                CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

    logic       sclk_lvl_unused, sclk_rise, sclk_fall;
    logic       ss_s, ss_rise, ss_fall;
    logic       mosi_s;
    logic [1:0] mosi_edges_unused;

    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .din(sclk),
        .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
        .clk(clk), .reset_n(reset_n), .din(ss),
        .level(ss_s), .rise(ss_rise), .fall(ss_fall)
    );
    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .din(mosi),
        .level(mosi_s), .rise(mosi_edges_unused[1]), .fall(mosi_edges_unused[0])
    );

    spi_state_t        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
    logic              tx_full_q, tx_full_d;
    logic              first_q, first_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] rx_data_d;
    logic              rx_valid_d;
    logic              miso_d;
    logic              load, done;
    logic              sample_rise, sample_edge, shift_edge;
    logic [DATA_W-1:0] done_byte;
`ifdef SPI_SLV_ERR_FLAGS_EN
    logic              ovr_d, und_d;
`endif

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rx_shift_d  = rx_shift_q;
        tx_buf_d    = tx_buf_q;
        tx_full_d   = tx_full_q;
        first_d     = first_q;
        pend_d      = pend_q;
        rx_data_d   = rx_data;
        rx_valid_d  = rx_valid;
`ifdef SPI_SLV_ERR_FLAGS_EN
        ovr_d       = 1'b0;
        und_d       = 1'b0;
`endif
        load        = 1'b0;
        done        = 1'b0;
        sample_rise = sample_on_rise(CPOL, CPHA);
        sample_edge = sample_rise ? sclk_rise : sclk_fall;
        shift_edge  = sample_rise ? sclk_fall : sclk_rise;
        done_byte   = {mosi_s, rx_shift_q[DATA_W-1:1]};

        case (state_q)
            SPI_IDLE: begin
                if (ss_rise) begin
                    load      = 1'b1;
                    bit_cnt_d = '0;
                    first_d   = CPHA;
                    pend_d    = 1'b0;
                    state_d   = SPI_ACTIVE;
                end
            end
            SPI_ACTIVE: begin
                if (ss_fall) begin
                    bit_cnt_d = '0;
                    pend_d    = 1'b0;
                    state_d   = SPI_IDLE;
                end else if (sample_edge) begin
                    rx_shift_d = done_byte;
                    if (bit_cnt_q == LAST_BIT) begin
                        done      = 1'b1;
                        bit_cnt_d = '0;
                        pend_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (shift_edge) begin
                    // back-to-back byte: the next frame is loaded in place of a shift
                    if (pend_q) begin
                        load    = 1'b1;
                        pend_d  = 1'b0;
                        first_d = 1'b0;
                    end else if (first_q) begin
                        first_d = 1'b0;
                    end else begin
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
            default: state_d = SPI_IDLE;
        endcase

        if (load) begin
            shreg_d   = tx_full_q ? tx_buf_q : DEFAULT_TX;
            tx_full_d = 1'b0;
`ifdef SPI_SLV_ERR_FLAGS_EN
            und_d     = ~tx_full_q;
`endif
        end

        if (tx_valid && !tx_full_q) begin
            tx_buf_d  = tx_data;
            tx_full_d = 1'b1;
        end

        if (rx_valid && rx_ready) rx_valid_d = 1'b0;

        if (done) begin
`ifdef SPI_SLV_ERR_FLAGS_EN
            if (rx_valid && !rx_ready) begin
                ovr_d = 1'b1;
            end else begin
                rx_data_d  = done_byte;
                rx_valid_d = 1'b1;
            end
`else
            rx_data_d  = done_byte;
            rx_valid_d = 1'b1;
`endif
        end

        // registered from the next shreg value so miso moves one clk after the sync edge
        miso_d = ss_s & shreg_d[0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= SPI_IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            rx_shift_q  <= '0;
            tx_buf_q    <= '0;
            tx_full_q   <= 1'b0;
            first_q     <= 1'b0;
            pend_q      <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            miso        <= 1'b0;
`ifdef SPI_SLV_ERR_FLAGS_EN
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rx_shift_q  <= rx_shift_d;
            tx_buf_q    <= tx_buf_d;
            tx_full_q   <= tx_full_d;
            first_q     <= first_d;
            pend_q      <= pend_d;
            rx_data     <= rx_data_d;
            rx_valid    <= rx_valid_d;
            miso        <= miso_d;
`ifdef SPI_SLV_ERR_FLAGS_EN
            rx_overrun  <= ovr_d;
            tx_underrun <= und_d;
`endif
        end
    end

    assign tx_ready = ~tx_full_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: table of single-frame vectors over all SPI modes,
// then hand-written back-to-back, abort, underrun, overrun and mid-frame reset sequences.
module tb_spi_slave_sync;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cpol = 1'b0, cpha = 1'b0;
    logic       sclk = 1'b0, ss = 1'b0, mosi = 1'b0;
    logic       miso;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
`ifdef SPI_SLV_ERR_FLAGS_EN
    logic       rx_overrun, tx_underrun;
    int         und_cnt = 0, ovr_cnt = 0;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic       mon_en = 1'b0;
    logic [7:0] rx_q[$];

    spi_slave_sync #(.DATA_W(8), .SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) dut (
        .clk(clk), .reset_n(reset_n), .CPOL(cpol), .CPHA(cpha),
        .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
`ifdef SPI_SLV_ERR_FLAGS_EN
        .rx_overrun(rx_overrun), .tx_underrun(tx_underrun),
`endif
        .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en && rx_valid && rx_ready) rx_q.push_back(rx_data);
`ifdef SPI_SLV_ERR_FLAGS_EN
        if (tx_underrun) und_cnt++;
        if (rx_overrun) ovr_cnt++;
`endif
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic [7:0] tx;
        logic [7:0] mosi_byte;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_mode(input logic p, input logic h);
        cpol = p;
        cpha = h;
        sclk = p;
        wait_clk(5);
    endtask

    task automatic push(input logic [7:0] b);
        int n = 0;
        while (!tx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi = mo[i];
                wait_clk(HALF);
                sclk  = ~cpol;
                mi[i] = miso;
                wait_clk(HALF);
                sclk  = cpol;
            end else begin
                wait_clk(HALF);
                sclk = ~cpol;
                mosi = mo[i];
                wait_clk(HALF);
                sclk  = cpol;
                mi[i] = miso;
            end
        end
    endtask

    task automatic frame(input logic [7:0] mo, output logic [7:0] mi);
        ss = 1'b1;
        xfer(mo, 8, mi);
        wait_clk(HALF);
        ss = 1'b0;
        wait_clk(8);
    endtask

    task automatic accept_rx();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] mi, mi2;

        vecs[0] = '{1'b0, 1'b0, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
        vecs[1] = '{1'b0, 1'b1, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
        vecs[2] = '{1'b1, 1'b0, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
        vecs[3] = '{1'b1, 1'b1, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF, 8'h00};
        vecs[5] = '{1'b1, 1'b1, 8'h81, 8'h6E, 8'h6E, 8'h81};

        wait_clk(3);
        check("rst_miso", miso, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 8'h00);
        reset_n = 1'b1;
        wait_clk(3);

        for (int i = 0; i < 6; i++) begin
            set_mode(vecs[i].cpol, vecs[i].cpha);
            push(vecs[i].tx);
            frame(vecs[i].mosi_byte, mi);
            check($sformatf("v%0d_rx_valid", i), rx_valid, 1);
            check($sformatf("v%0d_rx_data", i), rx_data, vecs[i].exp_rx);
            check($sformatf("v%0d_master_rx", i), mi, vecs[i].exp_miso);
            accept_rx();
            check($sformatf("v%0d_rx_taken", i), rx_valid, 0);
        end

        // back-to-back bytes with ss held, consumer always ready
        set_mode(1'b0, 1'b0);
        push(8'h11);
        rx_ready = 1'b1;
        mon_en   = 1'b1;
        ss = 1'b1;
        wait_clk(6);
        check("b2b_tx_ready_load1", tx_ready, 1);
        push(8'h22);
        check("b2b_tx_full", tx_ready, 0);
        xfer(8'h11, 8, mi);
        wait_clk(6);
        check("b2b_tx_ready_load2", tx_ready, 1);
        xfer(8'h22, 8, mi2);
        wait_clk(HALF);
        ss = 1'b0;
        wait_clk(8);
        mon_en   = 1'b0;
        rx_ready = 1'b0;
        check("b2b_rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("b2b_rx0", rx_q[0], 8'h11);
            check("b2b_rx1", rx_q[1], 8'h22);
        end
        check("b2b_master0", mi, 8'h11);
        check("b2b_master1", mi2, 8'h22);

        // abort after 4 bits, then a clean frame
        push(8'h99);
        ss = 1'b1;
        xfer(8'hF0, 4, mi);
        wait_clk(HALF);
        ss = 1'b0;
        wait_clk(10);
        check("abort_rx_valid", rx_valid, 0);
        check("abort_miso_idle", miso, 0);
        push(8'hC3);
        frame(8'h5A, mi);
        check("abort_next_rx_valid", rx_valid, 1);
        check("abort_next_rx", rx_data, 8'h5A);
        check("abort_next_master", mi, 8'hC3);
        accept_rx();

        // empty tx buffer -> DEFAULT_TX
        set_mode(1'b0, 1'b1);
        check("under_tx_empty", tx_ready, 1);
`ifdef SPI_SLV_ERR_FLAGS_EN
        und_cnt = 0;
`endif
        frame(8'h00, mi);
        check("under_master", mi, 8'hFF);
        check("under_rx", rx_data, 8'h00);
`ifdef SPI_SLV_ERR_FLAGS_EN
        check("under_pulses", und_cnt, 1);
`endif
        accept_rx();

        // consumer stalled across two frames
        set_mode(1'b1, 1'b0);
`ifdef SPI_SLV_ERR_FLAGS_EN
        ovr_cnt = 0;
`endif
        frame(8'h01, mi);
        frame(8'h02, mi);
        check("ovr_rx_valid", rx_valid, 1);
`ifdef SPI_SLV_ERR_FLAGS_EN
        check("ovr_rx_data", rx_data, 8'h01);
        check("ovr_pulses", ovr_cnt, 1);
`else
        check("ovr_rx_data", rx_data, 8'h02);
`endif

        // reset mid-frame
        ss = 1'b1;
        wait_clk(HALF);
        push(8'h77);
        xfer(8'h0F, 4, mi);
        check("mid_pre_miso", miso, 1);
        check("mid_pre_tx_ready", tx_ready, 0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_miso", miso, 0);
        check("mid_rst_tx_ready", tx_ready, 1);
        check("mid_rst_rx_valid", rx_valid, 0);
        check("mid_rst_rx_data", rx_data, 8'h00);
        @(negedge clk);
        ss   = 1'b0;
        sclk = cpol;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(5);
        frame(8'h44, mi);
        check("post_rst_rx_valid", rx_valid, 1);
        check("post_rst_rx", rx_data, 8'h44);
        check("post_rst_master", mi, 8'hFF);
        accept_rx();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
